endec_job_scheduler: RTL and testbench
======================================

// Module: endec_job_scheduler
// PURPOSE
// Round-robin scheduler sharing one endec core (conv. encoder + Viterbi decoder) between two job requesters.
// Accepts one job descriptor (code rate, gen poly, frames, prev encoder state), pulses core reset,
// enables the core, collects both done flags with a timeout, returns results on a valid/ready response port.
// PARAMETERS
// NREQ        2     requester count (fixed 2; round-robin pointer is 1 bit)
// POLY_W      27    gen-poly width (MAX_CONSTRAINT_LENGTH*MAX_CODE_RATE)
// STATE_W     8     encoder state width (MAX_STATE_REG_NUM)
// ENC_W       128   encoder input frame / decoder output width
// DEC_W       384   decoder input frame / encoder output width
// RST_CYC     2     cycles core_rst held low per job (>=1)
// TIMEOUT_CYC 1023  max RUN cycles before abort (<2^10)
// PORTS
// sys_clk        in   1             clock
// rst_n          in   1             async active-low reset
// req_valid      in   2             job request per requester
// req_ready      out  2             job accepted (combinational, one-hot)
// req_code_rate  in   2             per-requester code-rate select
// req_gen_poly   in   2*POLY_W      flattened, requester i at [i*POLY_W +: POLY_W]
// req_enc_frame  in   2*ENC_W       flattened data to encode
// req_dec_frame  in   2*DEC_W       flattened data to decode
// req_prv_state  in   2*STATE_W     flattened previous encoder state
// rsp_valid      out  1             result available
// rsp_ready      in   1             sink accepts result
// rsp_id         out  1             requester owning result
// rsp_timeout    out  1             job aborted by timeout
// rsp_enc_data   out  DEC_W         encoder result
// rsp_dec_data   out  ENC_W         decoder result
// core_rst       out  1             core reset, active-low
// core_en        out  1             core enable
// core_code_rate/core_gen_poly/core_enc_frame/core_dec_frame/core_prv_state  out  latched descriptor
// core_enc_done  in   1             core encoder done
// core_dec_done  in   1             core decoder done
// core_enc_data  in   DEC_W         core encoder output
// core_dec_data  in   ENC_W         core decoder output
// BEHAVIOUR
// Reset: state IDLE, rr_ptr=0, core_rst=0, core_en=0, rsp_valid=0, rsp_* =0, descriptor regs=0, counters=0.
// FSM IDLE->LOAD->RUN->RESP->IDLE; all outputs registered except req_ready.
// IDLE: grant = sole valid requester; both valid -> requester != rr_ptr. req_ready[g]=1 only in IDLE.
//   Handshake (valid&ready) latches descriptor g, rsp_id<=g, rr_ptr<=g, -> LOAD. core_rst=0, core_en=0.
// LOAD: core_rst=0 exactly RST_CYC cycles, core_en=0; clear done flags, data regs, timer -> RUN.
// RUN: core_rst=1, core_en=1. enc_seen/dec_seen sticky; core data captured on the cycle its done first is 1.
//   Both seen (incl. same cycle, incl. this cycle's done) -> RESP next cycle, rsp_timeout=0.
//   Timer counts RUN cycles; at TIMEOUT_CYC without both -> RESP, rsp_timeout=1, unseen data stays 0.
// RESP: rsp_valid=1, data stable; core_en=0, core_rst=1 (core outputs held). rsp_valid&rsp_ready -> IDLE,
//   rsp_valid=0 next cycle. Back-pressure unlimited; requests ignored (req_ready=0) while busy.
// Latency: accept cycle T -> core_en=1 at T+1+RST_CYC; both done at cycle D -> rsp_valid at D+1.
// Descriptor inputs sampled only at handshake; later changes ignored.
// Async reset mid-job: immediate return to reset values; partial job discarded, no response.
// TESTING
// Single job req0, dones at RUN cycle 10 -> core_rst low 2 cycles, rsp_valid 1 cycle later, rsp_id=0, timeout=0.
// req0,req1 both valid from reset -> grants req1 then req0 (rr_ptr=0), alternating while both held.
// enc_done at RUN cycle 5, dec_done at cycle 40 -> enc data captured at 5, rsp at 41, both data correct.
// Neither done -> after 1023 RUN cycles rsp_valid=1, rsp_timeout=1, rsp_enc_data=rsp_dec_data=0.
// rsp_ready low 20 cycles -> rsp_valid/data stable, req_ready=0 throughout; accept -> IDLE next cycle.
// rst_n low during RUN -> core_en=0, core_rst=0, rsp_valid=0 immediately; next job proceeds normally.

Source files
------------

// File: rtl/endec_job_if.sv
// Requester/response bundle for the endec job scheduler.
// master: job source and result sink (drives req_* payload and rsp_ready).
// slave : scheduler (drives req_ready and the rsp_* result).
// req_* buses are flattened; requester i occupies [i*W +: W].
interface endec_job_if #(
    parameter int unsigned POLY_W  = 27,
    parameter int unsigned STATE_W = 8,
    parameter int unsigned ENC_W   = 128,
    parameter int unsigned DEC_W   = 384
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0]           req_code_rate;
    logic [2*POLY_W-1:0]  req_gen_poly;
    logic [2*ENC_W-1:0]   req_enc_frame;
    logic [2*DEC_W-1:0]   req_dec_frame;
    logic [2*STATE_W-1:0] req_prv_state;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic                 rsp_timeout;
    logic [DEC_W-1:0]     rsp_enc_data;
    logic [ENC_W-1:0]     rsp_dec_data;

    modport master (
        output req_valid, req_code_rate, req_gen_poly, req_enc_frame, req_dec_frame,
               req_prv_state, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_timeout, rsp_enc_data, rsp_dec_data
    );

    modport slave (
        input  req_valid, req_code_rate, req_gen_poly, req_enc_frame, req_dec_frame,
               req_prv_state, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_timeout, rsp_enc_data, rsp_dec_data
    );
endinterface

// File: rtl/endec_job_scheduler.sv
// Round-robin scheduler sharing one endec core between two requesters.
// Ports: sys_clk/rst_n (async active-low); job (slave side of endec_job_if:
// request handshake with descriptors, result valid/ready port);
// core_* outputs: active-low core reset, enable and latched descriptor;
// core_* inputs: encoder/decoder done flags and result data.
// Only job.req_ready is combinational; everything else leaves a flop.
module endec_job_scheduler #(
    parameter int unsigned POLY_W      = 27,
    parameter int unsigned STATE_W     = 8,
    parameter int unsigned ENC_W       = 128,
    parameter int unsigned DEC_W       = 384,
    parameter int unsigned RST_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    endec_job_if.slave         job,
    output logic               core_rst,
    output logic               core_en,
    output logic               core_code_rate,
    output logic [POLY_W-1:0]  core_gen_poly,
    output logic [ENC_W-1:0]   core_enc_frame,
    output logic [DEC_W-1:0]   core_dec_frame,
    output logic [STATE_W-1:0] core_prv_state,
    input  logic               core_enc_done,
    input  logic               core_dec_done,
    input  logic [DEC_W-1:0]   core_enc_data,
    input  logic [ENC_W-1:0]   core_dec_data
);
    localparam int unsigned TMR_W = 10;
    localparam int unsigned RC_W  = $clog2(RST_CYC) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

    state_e             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               enc_seen_q, enc_seen_d;
    logic               dec_seen_q, dec_seen_d;
    logic               core_rst_q, core_rst_d;
    logic               core_en_q, core_en_d;
    logic               rate_q, rate_d;
    logic [POLY_W-1:0]  poly_q, poly_d;
    logic [ENC_W-1:0]   efrm_q, efrm_d;
    logic [DEC_W-1:0]   dfrm_q, dfrm_d;
    logic [STATE_W-1:0] prv_q, prv_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic               rsp_to_q, rsp_to_d;
    logic [DEC_W-1:0]   enc_data_q, enc_data_d;
    logic [ENC_W-1:0]   dec_data_q, dec_data_d;
    logic               grant_id;
    logic [1:0]         req_ready_c;

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            rst_cnt_q   <= '0;
            tmr_q       <= '0;
            enc_seen_q  <= 1'b0;
            dec_seen_q  <= 1'b0;
            core_rst_q  <= 1'b0;
            core_en_q   <= 1'b0;
            rate_q      <= 1'b0;
            poly_q      <= '0;
            efrm_q      <= '0;
            dfrm_q      <= '0;
            prv_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_to_q    <= 1'b0;
            enc_data_q  <= '0;
            dec_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            rst_cnt_q   <= rst_cnt_d;
            tmr_q       <= tmr_d;
            enc_seen_q  <= enc_seen_d;
            dec_seen_q  <= dec_seen_d;
            core_rst_q  <= core_rst_d;
            core_en_q   <= core_en_d;
            rate_q      <= rate_d;
            poly_q      <= poly_d;
            efrm_q      <= efrm_d;
            dfrm_q      <= dfrm_d;
            prv_q       <= prv_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_to_q    <= rsp_to_d;
            enc_data_q  <= enc_data_d;
            dec_data_q  <= dec_data_d;
        end
    end

    // Next-state, grant and output decode
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        rst_cnt_d   = rst_cnt_q;
        tmr_d       = tmr_q;
        enc_seen_d  = enc_seen_q;
        dec_seen_d  = dec_seen_q;
        rate_d      = rate_q;
        poly_d      = poly_q;
        efrm_d      = efrm_q;
        dfrm_d      = dfrm_q;
        prv_d       = prv_q;
        rsp_id_d    = rsp_id_q;
        rsp_to_d    = rsp_to_q;
        enc_data_d  = enc_data_q;
        dec_data_d  = dec_data_q;
        req_ready_c = 2'b00;
        // Contention goes to the requester not served last
        grant_id    = (&job.req_valid) ? ~rr_ptr_q : job.req_valid[1];

        unique case (state_q)
            IDLE: begin
                if (|job.req_valid) begin
                    req_ready_c[grant_id] = 1'b1;
                    rate_d    = job.req_code_rate[grant_id];
                    poly_d    = job.req_gen_poly[POLY_W*32'(grant_id) +: POLY_W];
                    efrm_d    = job.req_enc_frame[ENC_W*32'(grant_id) +: ENC_W];
                    dfrm_d    = job.req_dec_frame[DEC_W*32'(grant_id) +: DEC_W];
                    prv_d     = job.req_prv_state[STATE_W*32'(grant_id) +: STATE_W];
                    rsp_id_d  = grant_id;
                    rr_ptr_d  = grant_id;
                    rst_cnt_d = '0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                enc_seen_d = 1'b0;
                dec_seen_d = 1'b0;
                enc_data_d = '0;
                dec_data_d = '0;
                rsp_to_d   = 1'b0;
                tmr_d      = '0;
                if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            RUN: begin
                enc_seen_d = enc_seen_q | core_enc_done;
                dec_seen_d = dec_seen_q | core_dec_done;
                // Capture only on the first done so later core activity cannot corrupt it
                if (core_enc_done && !enc_seen_q) enc_data_d = core_enc_data;
                if (core_dec_done && !dec_seen_q) dec_data_d = core_dec_data;
                tmr_d = tmr_q + TMR_W'(1);
                if (enc_seen_d && dec_seen_d) begin
                    state_d = RESP;
                end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    rsp_to_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (job.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs follow the state being entered
        core_en_d   = (state_d == RUN);
        core_rst_d  = (state_d == RUN) || (state_d == RESP);
        rsp_valid_d = (state_d == RESP);
    end

    assign job.req_ready    = req_ready_c;
    assign job.rsp_valid    = rsp_valid_q;
    assign job.rsp_id       = rsp_id_q;
    assign job.rsp_timeout  = rsp_to_q;
    assign job.rsp_enc_data = enc_data_q;
    assign job.rsp_dec_data = dec_data_q;
    assign core_rst         = core_rst_q;
    assign core_en          = core_en_q;
    assign core_code_rate   = rate_q;
    assign core_gen_poly    = poly_q;
    assign core_enc_frame   = efrm_q;
    assign core_dec_frame   = dfrm_q;
    assign core_prv_state   = prv_q;
endmodule

// File: tb/tb_endec_job_scheduler.sv
// Directed bench for endec_job_scheduler: table of jobs plus reset-mid-run sequence.
module tb_endec_job_scheduler;
    localparam int unsigned POLY_W  = 27;
    localparam int unsigned STATE_W = 8;
    localparam int unsigned ENC_W   = 128;
    localparam int unsigned DEC_W   = 384;
    localparam int unsigned RST_CYC = 2;
    localparam int unsigned TMO     = 1023;

    logic               sys_clk;
    logic               rst_n;
    logic               core_rst, core_en, core_code_rate;
    logic [POLY_W-1:0]  core_gen_poly;
    logic [ENC_W-1:0]   core_enc_frame;
    logic [DEC_W-1:0]   core_dec_frame;
    logic [STATE_W-1:0] core_prv_state;
    logic               core_enc_done, core_dec_done;
    logic [DEC_W-1:0]   core_enc_data;
    logic [ENC_W-1:0]   core_dec_data;

    endec_job_if #(.POLY_W(POLY_W), .STATE_W(STATE_W), .ENC_W(ENC_W), .DEC_W(DEC_W)) job_if ();

    endec_job_scheduler #(
        .POLY_W(POLY_W), .STATE_W(STATE_W), .ENC_W(ENC_W), .DEC_W(DEC_W),
        .RST_CYC(RST_CYC), .TIMEOUT_CYC(TMO)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .job            (job_if),
        .core_rst       (core_rst),
        .core_en        (core_en),
        .core_code_rate (core_code_rate),
        .core_gen_poly  (core_gen_poly),
        .core_enc_frame (core_enc_frame),
        .core_dec_frame (core_dec_frame),
        .core_prv_state (core_prv_state),
        .core_enc_done  (core_enc_done),
        .core_dec_done  (core_dec_done),
        .core_enc_data  (core_enc_data),
        .core_dec_data  (core_dec_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // One job: who requests, RUN cycle of each done (-1 = never), response back-pressure
    typedef struct {
        logic [1:0] valid;
        int         enc_at;
        int         dec_at;
        int         hold;
        logic       exp_id;
        logic       exp_to;
    } vec_t;

    int n_test = 0;
    int n_fail = 0;

    logic [POLY_W-1:0]  gp [2];
    logic [ENC_W-1:0]   ef [2];
    logic [DEC_W-1:0]   df [2];
    logic [STATE_W-1:0] ps [2];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [DEC_W-1:0] enc_pat(input int i);
        return {12{32'hE000_0000 + 32'(i)}};
    endfunction

    function automatic logic [ENC_W-1:0] dec_pat(input int i);
        return {4{32'hD000_0000 + 32'(i)}};
    endfunction

    task automatic set_desc(input logic inv);
        job_if.req_code_rate = inv ? 2'b01 : 2'b10;
        job_if.req_gen_poly  = inv ? ~{gp[1], gp[0]} : {gp[1], gp[0]};
        job_if.req_enc_frame = inv ? ~{ef[1], ef[0]} : {ef[1], ef[0]};
        job_if.req_dec_frame = inv ? ~{df[1], df[0]} : {df[1], df[0]};
        job_if.req_prv_state = inv ? ~{ps[1], ps[0]} : {ps[1], ps[0]};
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int n;
        int k;
        int lat;
        int exp_lat;
        int rst_hi;
        logic [DEC_W-1:0] exp_enc;
        logic [ENC_W-1:0] exp_dec;
        logic [1:0] exp_rdy;
        string tag;
        tag = $sformatf("v%0d", vi);
        exp_rdy = v.exp_id ? 2'b10 : 2'b01;
        exp_enc = (v.enc_at >= 0) ? enc_pat(vi) : '0;
        exp_dec = (v.dec_at >= 0) ? dec_pat(vi) : '0;
        if (v.enc_at < 0 || v.dec_at < 0) exp_lat = TMO;
        else exp_lat = ((v.enc_at > v.dec_at) ? v.enc_at : v.dec_at) + 1;

        set_desc(1'b0);
        job_if.req_valid = v.valid;
        #1;
        chk({tag, " req_ready"}, 512'(job_if.req_ready), 512'(exp_rdy));
        step();
        job_if.req_valid = 2'b00;
        set_desc(1'b1);

        // LOAD: core held in reset, disabled
        n = 0;
        rst_hi = 0;
        while (core_en !== 1'b1 && n < 10) begin
            if (core_rst !== 1'b0) rst_hi++;
            n++;
            step();
        end
        chk({tag, " load_cycles"}, 512'(n), 512'(RST_CYC));
        chk({tag, " load_rst_high"}, 512'(rst_hi), 512'(0));
        chk({tag, " core_rst_run"}, 512'(core_rst), 512'(1));
        chk({tag, " code_rate"}, 512'(core_code_rate), 512'(v.exp_id));
        chk({tag, " gen_poly"}, 512'(core_gen_poly), 512'(gp[v.exp_id]));
        chk({tag, " enc_frame"}, 512'(core_enc_frame), 512'(ef[v.exp_id]));
        chk({tag, " dec_frame"}, 512'(core_dec_frame), 512'(df[v.exp_id]));
        chk({tag, " prv_state"}, 512'(core_prv_state), 512'(ps[v.exp_id]));

        // RUN: done held from its cycle on, data valid only on its first cycle
        k = 0;
        lat = -1;
        while (k < 1100) begin
            if (job_if.rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
            core_enc_done = (v.enc_at >= 0) && (k >= v.enc_at);
            core_dec_done = (v.dec_at >= 0) && (k >= v.dec_at);
            core_enc_data = (k == v.enc_at) ? enc_pat(vi) : ~enc_pat(vi);
            core_dec_data = (k == v.dec_at) ? dec_pat(vi) : ~dec_pat(vi);
            step();
            k++;
        end
        core_enc_done = 1'b0;
        core_dec_done = 1'b0;
        chk({tag, " rsp_latency"}, 512'(lat), 512'(exp_lat));
        chk({tag, " rsp_id"}, 512'(job_if.rsp_id), 512'(v.exp_id));
        chk({tag, " rsp_timeout"}, 512'(job_if.rsp_timeout), 512'(v.exp_to));
        chk({tag, " rsp_enc_data"}, 512'(job_if.rsp_enc_data), 512'(exp_enc));
        chk({tag, " rsp_dec_data"}, 512'(job_if.rsp_dec_data), 512'(exp_dec));
        chk({tag, " resp_core_en"}, 512'(core_en), 512'(0));
        chk({tag, " resp_core_rst"}, 512'(core_rst), 512'(1));

        // Back-pressure with competing requests that must be ignored
        for (int h = 0; h < v.hold; h++) begin
            job_if.req_valid = 2'b11;
            #1;
            chk({tag, " hold_valid"}, 512'(job_if.rsp_valid), 512'(1));
            chk({tag, " hold_req_ready"}, 512'(job_if.req_ready), 512'(0));
            chk({tag, " hold_enc"}, 512'(job_if.rsp_enc_data), 512'(exp_enc));
            chk({tag, " hold_dec"}, 512'(job_if.rsp_dec_data), 512'(exp_dec));
            step();
        end
        job_if.req_valid = 2'b00;
        job_if.rsp_ready = 1'b1;
        step();
        job_if.rsp_ready = 1'b0;
        chk({tag, " rsp_valid_drop"}, 512'(job_if.rsp_valid), 512'(0));
    endtask

    vec_t tbl[6];
    vec_t fin;

    initial begin
        int n;
        gp[0] = 27'h123_4567;  gp[1] = 27'h765_4321;
        ef[0] = {4{32'hA5A5_0000}};  ef[1] = {4{32'h5A5A_0001}};
        df[0] = {12{32'h0F0F_1000}}; df[1] = {12{32'hF0F0_2001}};
        ps[0] = 8'h3C;  ps[1] = 8'hC5;

        tbl[0] = '{2'b01, 10, 10, 0,  1'b0, 1'b0};
        tbl[1] = '{2'b11, 3,  3,  0,  1'b1, 1'b0};
        tbl[2] = '{2'b11, 5,  40, 0,  1'b0, 1'b0};
        tbl[3] = '{2'b10, 7,  2,  20, 1'b1, 1'b0};
        tbl[4] = '{2'b01, -1, -1, 0,  1'b0, 1'b1};
        tbl[5] = '{2'b11, 0,  -1, 3,  1'b1, 1'b1};
        fin    = '{2'b11, 1,  1,  0,  1'b1, 1'b0};

        rst_n = 1'b0;
        job_if.req_valid = 2'b00;
        job_if.rsp_ready = 1'b0;
        set_desc(1'b0);
        core_enc_done = 1'b0;
        core_dec_done = 1'b0;
        core_enc_data = '0;
        core_dec_data = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        step();

        chk("reset core_rst", 512'(core_rst), 512'(0));
        chk("reset core_en", 512'(core_en), 512'(0));
        chk("reset rsp_valid", 512'(job_if.rsp_valid), 512'(0));
        chk("reset rsp_id", 512'(job_if.rsp_id), 512'(0));
        chk("reset rsp_timeout", 512'(job_if.rsp_timeout), 512'(0));
        chk("reset rsp_enc_data", 512'(job_if.rsp_enc_data), 512'(0));
        chk("reset core_gen_poly", 512'(core_gen_poly), 512'(0));
        chk("reset req_ready", 512'(job_if.req_ready), 512'(0));

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // Async reset while the core is running
        set_desc(1'b0);
        job_if.req_valid = 2'b01;
        #1;
        chk("mid req_ready", 512'(job_if.req_ready), 512'(2'b01));
        step();
        job_if.req_valid = 2'b00;
        n = 0;
        while (core_en !== 1'b1 && n < 10) begin
            n++;
            step();
        end
        chk("mid core_en_up", 512'(core_en), 512'(1));
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid core_en", 512'(core_en), 512'(0));
        chk("mid core_rst", 512'(core_rst), 512'(0));
        chk("mid rsp_valid", 512'(job_if.rsp_valid), 512'(0));
        chk("mid core_gen_poly", 512'(core_gen_poly), 512'(0));
        @(negedge sys_clk);
        rst_n = 1'b1;
        step();
        repeat (3) begin
            chk("post rst idle rsp_valid", 512'(job_if.rsp_valid), 512'(0));
            step();
        end
        run_vec(fin, 6);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end
endmodule
